// File: rtl/branch_redirect_pkg.sv
// Shared encodings for the branch redirect unit: branch types, ARM condition
// codes, flag bit positions and the redirect FSM state encoding.
package branch_redirect_pkg;

    localparam logic [2:0] BR_NONE  = 3'd0;
    localparam logic [2:0] BR_B     = 3'd1;
    localparam logic [2:0] BR_CBZ   = 3'd2;
    localparam logic [2:0] BR_CBNZ  = 3'd3;
    localparam logic [2:0] BR_BCOND = 3'd4;
    localparam logic [2:0] BR_BR    = 3'd5;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_HS = 4'd2;
    localparam logic [3:0] COND_LO = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Shadow counter width covers SHADOW_CYCLES up to 7.
    localparam int SHADOW_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SHADOW   = 2'd2
    } state_e;

endpackage

// File: rtl/branch_redirect_cond_eval.sv
// ARM condition-code evaluation: purely combinational, cond + {N,Z,C,V} -> pass.
module cond_eval
    import branch_redirect_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_HS: pass = c;
            COND_LO: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_redirect.sv
// Branch resolution and PC redirect: decides taken/target in the accept cycle,
// then strobes en_jump once and holds flush for SHADOW_CYCLES cycles.
module branch_redirect
    import branch_redirect_pkg::*;
#(
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [63:0]      pc_in,
    input  logic [63:0]      imm,
    input  logic [63:0]      reg_val,
    input  logic [3:0]       cond,
    input  logic [3:0]       flags,
    output logic [63:0]      jump,
    output logic             en_jump,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] taken_count,
    output state_e           state_dbg
);

    localparam logic [SHADOW_W-1:0] SHADOW_LOAD = SHADOW_W'(SHADOW_CYCLES - 1);
    localparam logic [SHADOW_W-1:0] SHADOW_ONE  = SHADOW_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

    state_e              state;
    logic [SHADOW_W-1:0] shadow_cnt;
    logic                cond_pass;
    logic                taken;
    logic [63:0]         target;

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (flags),
        .pass  (cond_pass)
    );

    // Types 6 and 7 fall into the default arm and behave as "none".
    always_comb begin
        taken  = 1'b0;
        target = pc_in + imm;
        case (br_type)
            BR_B:     taken = 1'b1;
            BR_CBZ:   taken = (reg_val == 64'd0);
            BR_CBNZ:  taken = (reg_val != 64'd0);
            BR_BCOND: taken = cond_pass;
            BR_BR: begin
                taken  = 1'b1;
                target = reg_val;
            end
            default:  taken = 1'b0;
        endcase
    end

    // shadow_cnt counts the flush cycles still owed after the current one;
    // REDIRECT is itself the first flush cycle, so SHADOW lasts SHADOW_CYCLES-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            jump        <= 64'd0;
            en_jump     <= 1'b0;
            flush       <= 1'b0;
            busy        <= 1'b0;
            taken_count <= '0;
            shadow_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (br_valid && taken) begin
                        state      <= ST_REDIRECT;
                        jump       <= target - 64'd1;
                        en_jump    <= 1'b1;
                        flush      <= 1'b1;
                        busy       <= 1'b1;
                        shadow_cnt <= SHADOW_LOAD;
                        if (taken_count != '1) begin
                            taken_count <= taken_count + CNT_ONE;
                        end
                    end
                end
                ST_REDIRECT: begin
                    en_jump <= 1'b0;
                    if (shadow_cnt == '0) begin
                        state <= ST_IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        state      <= ST_SHADOW;
                        shadow_cnt <= shadow_cnt - SHADOW_ONE;
                    end
                end
                ST_SHADOW: begin
                    if (shadow_cnt == '0) begin
                        state <= ST_IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        shadow_cnt <= shadow_cnt - SHADOW_ONE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    en_jump <= 1'b0;
                    flush   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect: default instance plus a CNT_W=2 instance
// sharing the same stimulus for the saturation check.
module tb_branch_redirect;
    import branch_redirect_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        br_valid;
    logic [2:0]  br_type;
    logic [63:0] pc_in;
    logic [63:0] imm;
    logic [63:0] reg_val;
    logic [3:0]  cond;
    logic [3:0]  flags;

    logic [63:0] jump;
    logic        en_jump;
    logic        flush;
    logic        busy;
    logic [15:0] taken_count;
    state_e      state_dbg;

    logic [63:0] s_jump;
    logic        s_en_jump;
    logic        s_flush;
    logic        s_busy;
    logic [1:0]  s_taken_count;
    state_e      s_state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    logic [63:0] exp_q[$];

    branch_redirect dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .br_valid    (br_valid),
        .br_type     (br_type),
        .pc_in       (pc_in),
        .imm         (imm),
        .reg_val     (reg_val),
        .cond        (cond),
        .flags       (flags),
        .jump        (jump),
        .en_jump     (en_jump),
        .flush       (flush),
        .busy        (busy),
        .taken_count (taken_count),
        .state_dbg   (state_dbg)
    );

    branch_redirect #(.SHADOW_CYCLES(2), .CNT_W(2)) dut_sat (
        .clock       (clock),
        .reset_n     (reset_n),
        .br_valid    (br_valid),
        .br_type     (br_type),
        .pc_in       (pc_in),
        .imm         (imm),
        .reg_val     (reg_val),
        .cond        (cond),
        .flags       (flags),
        .jump        (s_jump),
        .en_jump     (s_en_jump),
        .flush       (s_flush),
        .busy        (s_busy),
        .taken_count (s_taken_count),
        .state_dbg   (s_state_dbg)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_br(input logic [2:0] t, input logic [63:0] pc, input logic [63:0] im,
                          input logic [63:0] rv, input logic [3:0] c, input logic [3:0] f);
        br_valid = 1'b1;
        br_type  = t;
        pc_in    = pc;
        imm      = im;
        reg_val  = rv;
        cond     = c;
        flags    = f;
    endtask

    task automatic clear_br();
        br_valid = 1'b0;
        br_type  = BR_NONE;
        pc_in    = 64'd0;
        imm      = 64'd0;
        reg_val  = 64'd0;
        cond     = 4'd0;
        flags    = 4'd0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one branch, check the redirect cycle against the scoreboard,
    // then let the shadow drain and confirm the unit is idle again.
    task automatic run_branch(input string tag, input logic [2:0] t, input logic [63:0] pc,
                              input logic [63:0] im, input logic [63:0] rv,
                              input logic [3:0] c, input logic [3:0] f, input logic exp_take);
        logic [63:0] exp_jump;
        set_br(t, pc, im, rv, c, f);
        if (exp_take) begin
            exp_q.push_back((t == BR_BR) ? rv - 64'd1 : pc + im - 64'd1);
            exp_cnt++;
        end
        tick();
        clear_br();
        check({tag, ".en_jump"}, 64'(en_jump), 64'(exp_take));
        check({tag, ".flush"}, 64'(flush), 64'(exp_take));
        if (exp_take) begin
            exp_jump = exp_q.pop_front();
            check({tag, ".jump"}, jump, exp_jump);
        end
        tick();
        tick();
        check({tag, ".busy_end"}, 64'(busy), 64'd0);
    endtask

    logic [15:0] masks [3];
    logic [3:0]  fl    [3];

    initial begin
        masks[0] = 16'hE6A5;  fl[0] = 4'b0110;  // N0 Z1 C1 V0
        masks[1] = 16'hD65A;  fl[1] = 4'b1001;  // N1 Z0 C0 V1
        masks[2] = 16'hE996;  fl[2] = 4'b1010;  // N1 Z0 C1 V0

        clear_br();
        reset_n = 1'b0;
        #12;
        check("rst.jump", jump, 64'd0);
        check("rst.en_jump", 64'(en_jump), 64'd0);
        check("rst.flush", 64'(flush), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.count", 64'(taken_count), 64'd0);
        check("rst.state", 64'(state_dbg), 64'(ST_IDLE));
        @(negedge clock);
        reset_n = 1'b1;

        // B pc=100 imm=-4: target 96, jump 95
        set_br(BR_B, 64'd100, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 4'd0, 4'd0);
        tick();
        clear_br();
        check("b.en_jump_n1", 64'(en_jump), 64'd1);
        check("b.jump_n1", jump, 64'd95);
        check("b.flush_n1", 64'(flush), 64'd1);
        check("b.state_n1", 64'(state_dbg), 64'(ST_REDIRECT));
        tick();
        check("b.en_jump_n2", 64'(en_jump), 64'd0);
        check("b.flush_n2", 64'(flush), 64'd1);
        check("b.busy_n2", 64'(busy), 64'd1);
        check("b.jump_hold_n2", jump, 64'd95);
        tick();
        check("b.flush_n3", 64'(flush), 64'd0);
        check("b.busy_n3", 64'(busy), 64'd0);
        check("b.state_n3", 64'(state_dbg), 64'(ST_IDLE));
        exp_cnt = 1;
        check("b.count", 64'(taken_count), 64'(exp_cnt));

        // CBZ taken then not taken; jump must keep its old value
        run_branch("cbz0", BR_CBZ, 64'd10, 64'd3, 64'd0, 4'd0, 4'd0, 1'b1);
        run_branch("cbz5", BR_CBZ, 64'd10, 64'd3, 64'd5, 4'd0, 4'd0, 1'b0);
        check("cbz5.jump_hold", jump, 64'd12);
        run_branch("cbnz5", BR_CBNZ, 64'd40, 64'd2, 64'd5, 4'd0, 4'd0, 1'b1);
        run_branch("cbnz0", BR_CBNZ, 64'd40, 64'd2, 64'd0, 4'd0, 4'd0, 1'b0);
        run_branch("type6", 3'd6, 64'd40, 64'd2, 64'd0, 4'd0, 4'd0, 1'b0);
        run_branch("type7", 3'd7, 64'd40, 64'd2, 64'd0, 4'd0, 4'd0, 1'b0);
        set_br(BR_B, 64'd300, 64'd1, 64'd0, 4'd0, 4'd0);
        br_valid = 1'b0;
        tick();
        clear_br();
        check("novalid.en_jump", 64'(en_jump), 64'd0);
        check("novalid.busy", 64'(busy), 64'd0);

        // B.cond GT: N=1 V=1 Z=0 taken, with Z=1 not taken
        run_branch("gt_take", BR_BCOND, 64'd0, 64'd50, 64'd0, COND_GT, 4'b1001, 1'b1);
        run_branch("gt_z", BR_BCOND, 64'd0, 64'd50, 64'd0, COND_GT, 4'b1101, 1'b0);

        // Sweep all 16 codes against hand-derived truth masks
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 16; c++) begin
                run_branch($sformatf("cond%0d_p%0d", c, p), BR_BCOND, 64'(c * 10 + p * 1000),
                           64'd7, 64'd0, 4'(c), fl[p], masks[p][c]);
            end
        end
        check("sweep.count", 64'(taken_count), 64'(exp_cnt));

        // Wrong-path BRs during REDIRECT/SHADOW are ignored; BR to 0 accepted after
        set_br(BR_B, 64'd200, 64'd20, 64'd0, 4'd0, 4'd0);
        tick();
        check("wp.en_jump_n1", 64'(en_jump), 64'd1);
        check("wp.jump_n1", jump, 64'd219);
        set_br(BR_BR, 64'd0, 64'd0, 64'd500, 4'd0, 4'd0);
        tick();
        check("wp.en_jump_n2", 64'(en_jump), 64'd0);
        check("wp.flush_n2", 64'(flush), 64'd1);
        tick();
        check("wp.en_jump_n3", 64'(en_jump), 64'd0);
        check("wp.state_n3", 64'(state_dbg), 64'(ST_IDLE));
        set_br(BR_BR, 64'd0, 64'd0, 64'd0, 4'd0, 4'd0);
        tick();
        clear_br();
        check("wp.en_jump_n4", 64'(en_jump), 64'd1);
        check("wp.jump_n4", jump, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_cnt += 2;
        tick();
        tick();
        check("wp.count", 64'(taken_count), 64'(exp_cnt));

        // Asynchronous reset in SHADOW
        set_br(BR_B, 64'd1, 64'd1, 64'd0, 4'd0, 4'd0);
        tick();
        clear_br();
        tick();
        check("ar.flush_pre", 64'(flush), 64'd1);
        check("ar.state_pre", 64'(state_dbg), 64'(ST_SHADOW));
        #1;
        reset_n = 1'b0;
        #1;
        check("ar.flush", 64'(flush), 64'd0);
        check("ar.busy", 64'(busy), 64'd0);
        check("ar.count", 64'(taken_count), 64'd0);
        check("ar.jump", jump, 64'd0);
        check("ar.state", 64'(state_dbg), 64'(ST_IDLE));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        exp_cnt = 0;

        // First edge after release behaves as IDLE; five taken branches total
        run_branch("post_rst", BR_B, 64'd7, 64'd1, 64'd0, 4'd0, 4'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            run_branch($sformatf("sat%0d", k), BR_BR, 64'd0, 64'd0, 64'(k + 100), 4'd0,
                       4'd0, 1'b1);
        end
        check("sat.count16", 64'(taken_count), 64'(exp_cnt));
        check("sat.count2", 64'(s_taken_count), 64'd3);
        check("sat.jump2", s_jump, 64'd102);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
